// File: rtl/mult_div_pkg.sv
// Shared CPU constants: ALU and multiply/divide op encodings plus default
// multiply/divide latencies.
package mult_div_pkg;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  typedef enum logic [3:0] {
    ALU_ADD = 4'b0000,
    ALU_SUB = 4'b0001,
    ALU_AND = 4'b0010,
    ALU_OR  = 4'b0011,
    ALU_XOR = 4'b0100,
    ALU_NOR = 4'b0101,
    ALU_SLT = 4'b0110,
    ALU_SLTU = 4'b0111,
    ALU_LUI = 4'b1000
  } alu_op_e;

  typedef enum logic [3:0] {
    MD_NONE  = 4'b0000,
    MD_MULT  = 4'b0001,
    MD_MULTU = 4'b0010,
    MD_DIV   = 4'b0011,
    MD_DIVU  = 4'b0100,
    MD_MTHI  = 4'b0101,
    MD_MTLO  = 4'b0110
  } md_op_e;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } md_state_e;

  // Multi-cycle ops are the ones that occupy the unit and raise Busy.
  function automatic logic is_long_op(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/mult_div.sv
// Multiply/divide unit with architectural HI/LO. Results are computed
// combinationally from latched operands; a down-counter only models latency.
module mult_div
  import mult_div_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [3:0]  MDOp,
  input  logic        Start,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);

  md_state_e   state, state_next;
  logic [CW-1:0] cnt;
  logic [31:0] a_q, b_q;
  logic [3:0]  op_q;
  logic        accepted_q;
  logic        accept, move_hi, move_lo, write_res;
  logic [63:0] result;
  logic [63:0] prod_s, prod_u;
  logic [31:0] quot_s, rem_s, quot_u, rem_u;

  assign accept  = Start && is_long_op(MDOp) && (state == ST_IDLE) && !accepted_q;
  assign move_hi = Start && (MDOp == MD_MTHI) && (state == ST_IDLE);
  assign move_lo = Start && (MDOp == MD_MTLO) && (state == ST_IDLE);

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (accept) state_next = ST_RUN;
      ST_RUN:  if (cnt == '0) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // A zero divisor still burns the full latency but never touches HI/LO.
  always_comb begin
    Busy      = (state == ST_RUN);
    write_res = 1'b0;
    if ((state == ST_RUN) && (cnt == '0)) begin
      if ((op_q == MD_DIV) || (op_q == MD_DIVU)) write_res = (b_q != 32'd0);
      else                                       write_res = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= MD_NONE;
      accepted_q <= 1'b0;
    end else begin
      accepted_q <= accept;
      if (accept) begin
        a_q  <= A;
        b_q  <= B;
        op_q <= MDOp;
        if ((MDOp == MD_MULT) || (MDOp == MD_MULTU)) cnt <= CW'(MULT_CYCLES - 1);
        else                                         cnt <= CW'(DIV_CYCLES - 1);
      end else if ((state == ST_RUN) && (cnt != '0)) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  assign prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
  assign prod_u = {32'd0, a_q} * {32'd0, b_q};
  assign quot_s = $unsigned($signed(a_q) / $signed(b_q));
  assign rem_s  = $unsigned($signed(a_q) % $signed(b_q));
  assign quot_u = a_q / b_q;
  assign rem_u  = a_q % b_q;

  always_comb begin
    result = '0;
    case (op_q)
      MD_MULT:  result = prod_s;
      MD_MULTU: result = prod_u;
      MD_DIV:   result = {rem_s, quot_s};
      MD_DIVU:  result = {rem_u, quot_u};
      default:  result = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      HI <= '0;
      LO <= '0;
    end else if (write_res) begin
      HI <= result[63:32];
      LO <= result[31:0];
    end else begin
      if (move_hi) HI <= A;
      if (move_lo) LO <= A;
    end
  end

endmodule

// File: tb/tb_mult_div.sv
// Self-checking bench for mult_div: directed corner cases with literal
// expectations plus randomized traffic against a behavioural HI/LO model.
module tb_mult_div;
  import mult_div_pkg::*;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        Start = 1'b0;
  logic [3:0]  MDOp = 4'd0;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic        Busy;
  logic [31:0] HI, LO;

  int checks = 0;
  int failures = 0;

  mult_div #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .A(A), .B(B), .MDOp(MDOp), .Start(Start),
    .Busy(Busy), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  // Behavioural model: remaining busy cycles plus a pending HI/LO result.
  logic [31:0] m_hi = 32'd0, m_lo = 32'd0, p_hi = 32'd0, p_lo = 32'd0;
  bit          p_write = 1'b0;
  int          m_rem = 0;
  bit          m_prev = 1'b0;
  bit          cmp_en = 1'b0;

  function automatic void computeResult(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b, output logic [31:0] hi,
                                        output logic [31:0] lo, output bit wr);
    longint          ps;
    longint unsigned pu;
    int              sa, sb;
    int unsigned     ua, ub;
    hi = 32'd0; lo = 32'd0; wr = 1'b1;
    sa = a; sb = b; ua = a; ub = b;
    case (op)
      4'd1: begin ps = longint'(sa) * longint'(sb); hi = ps[63:32]; lo = ps[31:0]; end
      4'd2: begin pu = longint'(ua) * longint'(ub); hi = pu[63:32]; lo = pu[31:0]; end
      4'd3: if (sb == 0) wr = 1'b0; else begin lo = sa / sb; hi = sa % sb; end
      4'd4: if (ub == 0) wr = 1'b0; else begin lo = ua / ub; hi = ua % ub; end
      default: wr = 1'b0;
    endcase
  endfunction

  always @(posedge clk) begin
    bit acc;
    acc = 1'b0;
    if (reset) begin
      m_hi = 32'd0; m_lo = 32'd0; m_rem = 0;
    end else if (m_rem > 0) begin
      m_rem = m_rem - 1;
      if (m_rem == 0 && p_write) begin m_hi = p_hi; m_lo = p_lo; end
    end else if (Start) begin
      if (MDOp >= 4'd1 && MDOp <= 4'd4 && !m_prev) begin
        computeResult(MDOp, A, B, p_hi, p_lo, p_write);
        m_rem = (MDOp <= 4'd2) ? MC : DC;
        acc = 1'b1;
      end else if (MDOp == 4'd5) m_hi = A;
      else if (MDOp == 4'd6) m_lo = A;
    end
    m_prev = acc;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      checkOutput("cyc_busy", {31'd0, Busy}, {31'd0, (m_rem > 0)});
      checkOutput("cyc_hi", HI, m_hi);
      checkOutput("cyc_lo", LO, m_lo);
    end
  end

  task automatic applyStimulus(input logic st, input logic [3:0] op,
                               input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    Start = st; MDOp = op; A = a; B = b;
    @(posedge clk);
    #1;
  endtask

  task automatic waitIdle(output int cycles);
    cycles = 0;
    while (Busy && cycles < 64) begin
      applyStimulus(1'b0, 4'd0, $urandom, $urandom);
      cycles++;
    end
    if (cycles >= 64) begin
      checks++; failures++;
      $display("[TB] FAIL busy_timeout actual=%0d expected<64", cycles);
    end
  endtask

  task automatic runOp(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int cycles);
    applyStimulus(1'b1, op, a, b);
    waitIdle(cycles);
  endtask

  initial begin
    int cyc, n;
    bit rst;
    logic [3:0] op;
    logic [31:0] ra, rb;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_busy", {31'd0, Busy}, 32'd0);
    checkOutput("reset_hi", HI, 32'd0);
    checkOutput("reset_lo", LO, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    cmp_en = 1'b1;

    runOp(MD_MULT, 32'hFFFFFFFF, 32'd2, cyc);
    checkOutput("mult_cycles", cyc, MC);
    checkOutput("mult_hi", HI, 32'hFFFFFFFF);
    checkOutput("mult_lo", LO, 32'hFFFFFFFE);
    checkOutput("model_mult_hi", m_hi, 32'hFFFFFFFF);

    runOp(MD_MULTU, 32'hFFFFFFFF, 32'd2, cyc);
    checkOutput("multu_cycles", cyc, MC);
    checkOutput("multu_hi", HI, 32'h00000001);
    checkOutput("multu_lo", LO, 32'hFFFFFFFE);

    runOp(MD_DIV, 32'hFFFFFFF9, 32'd2, cyc);
    checkOutput("div_cycles", cyc, DC);
    checkOutput("div_lo", LO, 32'hFFFFFFFD);
    checkOutput("div_hi", HI, 32'hFFFFFFFF);
    checkOutput("model_div_lo", m_lo, 32'hFFFFFFFD);

    runOp(MD_DIVU, 32'hFFFFFFF9, 32'd2, cyc);
    checkOutput("divu_lo", LO, 32'h7FFFFFFC);
    checkOutput("divu_hi", HI, 32'h00000001);
    checkOutput("model_divu_hi", m_hi, 32'h00000001);

    applyStimulus(1'b1, MD_MTHI, 32'h11, 32'd0);
    checkOutput("mthi_busy", {31'd0, Busy}, 32'd0);
    checkOutput("mthi_hi", HI, 32'h11);
    applyStimulus(1'b1, MD_MTLO, 32'h22, 32'd0);
    checkOutput("mtlo_lo", LO, 32'h22);
    runOp(MD_DIV, 32'd1234, 32'd0, cyc);
    checkOutput("divz_cycles", cyc, DC);
    checkOutput("divz_hi", HI, 32'h11);
    checkOutput("divz_lo", LO, 32'h22);

    applyStimulus(1'b1, MD_MULT, 32'd7, 32'd6);
    applyStimulus(1'b0, MD_NONE, 32'd0, 32'd0);
    applyStimulus(1'b1, MD_MTLO, 32'h55, 32'd0);
    applyStimulus(1'b1, MD_MULT, 32'd3, 32'd4);
    n = 3;
    waitIdle(cyc);
    checkOutput("overlap_cycles", n + cyc, MC);
    checkOutput("overlap_hi", HI, 32'd0);
    checkOutput("overlap_lo", LO, 32'd42);

    applyStimulus(1'b1, MD_MTHI, 32'h77, 32'd0);
    applyStimulus(1'b1, MD_DIV, 32'd100, 32'd7);
    repeat (3) applyStimulus(1'b0, MD_NONE, 32'd0, 32'd0);
    @(negedge clk);
    reset = 1'b1; Start = 1'b1; MDOp = MD_MULT; A = 32'd9; B = 32'd9;
    @(posedge clk);
    #1;
    checkOutput("rst_mid_busy", {31'd0, Busy}, 32'd0);
    checkOutput("rst_mid_hi", HI, 32'd0);
    checkOutput("rst_mid_lo", LO, 32'd0);
    @(negedge clk);
    reset = 1'b0; Start = 1'b0;
    repeat (12) applyStimulus(1'b0, MD_NONE, 32'd0, 32'd0);
    checkOutput("rst_after_hi", HI, 32'd0);
    checkOutput("rst_after_lo", LO, 32'd0);

    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      op = 4'($urandom_range(0, 7));
      ra = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 200)) : $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 2) == 0) begin
        rb = 32'($urandom_range(0, 50));
        if ($urandom_range(0, 1) == 1) rb = -rb;
      end
      if (op == 4'd3 && ra == 32'h80000000 && rb == 32'hFFFFFFFF) rb = 32'd1;
      @(negedge clk);
      reset = rst;
      Start = ($urandom_range(0, 2) != 0);
      MDOp = op; A = ra; B = rb;
      @(posedge clk);
    end

    @(negedge clk);
    reset = 1'b0; Start = 1'b0;
    waitIdle(cyc);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
